lc3_decode: RTL
===============

Name: lc3_decode

Overview:
- Decode stage of the LC3 pipeline, directly downstream of the fetch stage.
- Captures the instruction word from instruction memory (dout) and the fetch stage's next-PC (npc_in) on enable_decode.
- Produces a registered IR, a registered NPC and the execute, writeback and memory control words consumed by execute/writeback/memaccess.
- Inserts a bubble on flush when a branch is taken.

Parameters:
- RESET_IR, 16'h0000, IR value after reset/flush (LC3 NOP: BR with nzp=000)

Ports:
- clock  in  1  rising-edge clock
- reset  in  1  synchronous, active-high reset
- enable_decode  in  1  capture dout/npc_in this cycle
- flush  in  1  squash: load bubble (driven from br_taken path)
- dout  in  16  instruction word from instruction memory
- npc_in  in  16  next PC from fetch stage
- ir  out  16  registered instruction
- npc_out  out  16  registered NPC
- e_control  out  6  {alu_control[1:0], pcselect1[1:0], pcselect2, op2select}
- w_control  out  2  writeback select
- mem_control  out  1  1 = indirect memory access
- valid  out  1  outputs hold a real decoded instruction

Behaviour:
- All outputs registered; latency 1 cycle from enable_decode to outputs.
- Priority per clock edge: reset > flush > enable_decode > hold.
- reset=1: ir=RESET_IR, npc_out=0, e_control=0, w_control=0, mem_control=0, valid=0.
- flush=1 (with or without enable): same values as reset. flush wins over enable_decode in the same cycle.
- enable_decode=1, flush=0: ir<=dout, npc_out<=npc_in, valid<=1, controls decoded from dout[15:12].
- enable_decode=0: all outputs hold (stall).
- Decode table (opcode: alu, pcsel1, pcsel2, op2, w, mem):
  - ADD 0001 / AND 0101: alu 00 / 01, pcsel1 00, pcsel2 0, op2=~dout[5], w 00, mem 0.
  - NOT 1001: alu 10, 00, 0, op2 0, w 00, mem 0.
  - BR 0000, LD 0010, ST 0011, LDI 1010, STI 1011, LEA 1110: alu 11, pcsel1 01 (offset9), pcsel2 1 (NPC base), op2 0.
    - w: LD/LDI 10, LEA 01, others 00.
    - mem: 1 for LDI/STI only.
  - LDR 0110 / STR 0111: alu 11, pcsel1 10 (offset6), pcsel2 0 (BaseR), op2 0; w 10 for LDR, 00 for STR; mem 0.
  - JMP 1100: alu 11, pcsel1 11 (zero), pcsel2 0, op2 0, w 00, mem 0.
  - Any other opcode (JSR, RTI, reserved, TRAP): ir/npc captured, valid=1, all controls 0.
- No wrap or arithmetic inside this block; npc_in is passed through unmodified.

Optional Feature:
- Macro: LC3_DECODE_ILLEGAL_EN.
- Defined:
  - Adds output illegal_op (1 bit), registered alongside the other outputs.
  - illegal_op=1 when a captured opcode is 0100, 1000, 1101 or 1111.
  - Adds sticky output illegal_seen, set by any illegal capture and cleared only by reset.
  - flush clears illegal_op but not illegal_seen.
- Undefined: neither port exists; unsupported opcodes decode as all-zero controls only.

Decomposition:
- Package lc3_pkg holds:
  - opcode localparams (OP_ADD, OP_AND, ...)
  - alu_control, pcselect1 and w_control encodings as typedef enums
  - a packed struct typedef for e_control
- One combinational sub-module, lc3_decode_ctl, maps opcode + ir[5] to the control bundle. The top holds the registers and priority logic.

Test Plan:
- reset for 2 cycles -> ir=0000, npc_out=0000, e_control=000000, w=00, mem=0, valid=0.
- dout=16'h1283 (ADD R1,R2,R3), npc_in=3001, enable=1 -> next cycle ir=1283, npc_out=3001, e_control=000001, w=00, valid=1. Then dout=16'h12A5 -> e_control=000000.
- dout=16'hA003 (LDI) -> e_control=110110, w=10, mem=1. Then dout=16'hE9FF (LEA) -> e_control=110110, w=01, mem=0.
- dout=16'hC1C0 (JMP R7) with enable=1 and flush=1 in the same cycle -> ir=0000, valid=0. Next cycle flush=0 -> ir=C1C0, e_control=111100.
- enable_decode=0 for 3 cycles while dout changes -> ir, npc_out and controls hold their last values.
- With LC3_DECODE_ILLEGAL_EN: dout=16'hF025 (TRAP) -> illegal_op=1, illegal_seen=1, controls 0. Then flush -> illegal_op=0, illegal_seen stays 1.

Source files
------------

// File: rtl/lc3_pkg.sv
// Shared LC3 decode definitions: opcodes, control-field encodings and the execute control bundle.
package lc3_pkg;

  localparam logic [3:0] OP_BR  = 4'b0000;
  localparam logic [3:0] OP_ADD = 4'b0001;
  localparam logic [3:0] OP_LD  = 4'b0010;
  localparam logic [3:0] OP_ST  = 4'b0011;
  localparam logic [3:0] OP_JSR = 4'b0100;
  localparam logic [3:0] OP_AND = 4'b0101;
  localparam logic [3:0] OP_LDR = 4'b0110;
  localparam logic [3:0] OP_STR = 4'b0111;
  localparam logic [3:0] OP_RTI = 4'b1000;
  localparam logic [3:0] OP_NOT = 4'b1001;
  localparam logic [3:0] OP_LDI = 4'b1010;
  localparam logic [3:0] OP_STI = 4'b1011;
  localparam logic [3:0] OP_JMP = 4'b1100;
  localparam logic [3:0] OP_RES = 4'b1101;
  localparam logic [3:0] OP_LEA = 4'b1110;
  localparam logic [3:0] OP_TRAP = 4'b1111;

  typedef enum logic [1:0] {
    ALU_ADD  = 2'b00,
    ALU_AND  = 2'b01,
    ALU_NOT  = 2'b10,
    ALU_PASS = 2'b11
  } alu_ctl_e;

  typedef enum logic [1:0] {
    PCS1_OFF11 = 2'b00,
    PCS1_OFF9  = 2'b01,
    PCS1_OFF6  = 2'b10,
    PCS1_ZERO  = 2'b11
  } pcsel1_e;

  typedef enum logic [1:0] {
    W_ALU  = 2'b00,
    W_PC   = 2'b01,
    W_MEM  = 2'b10,
    W_RSVD = 2'b11
  } w_ctl_e;

  // Field order matches the e_control port: {alu, pcsel1, pcsel2, op2}
  typedef struct packed {
    alu_ctl_e alu;
    pcsel1_e  pcsel1;
    logic     pcsel2;
    logic     op2;
  } e_ctl_t;

  localparam e_ctl_t E_CTL_NONE = '{alu: ALU_ADD, pcsel1: PCS1_OFF11, pcsel2: 1'b0, op2: 1'b0};

endpackage

// File: rtl/lc3_decode_ctl.sv
// Combinational opcode decoder producing execute/writeback/memory controls.
// Illegal-opcode flag exists only when LC3_DECODE_ILLEGAL_EN is defined.
module lc3_decode_ctl
  import lc3_pkg::*;
(
  input  logic [3:0] opcode,
  input  logic       imm_bit,
  output e_ctl_t     e_ctl,
  output w_ctl_e     w_ctl,
  output logic       mem_ctl
`ifdef LC3_DECODE_ILLEGAL_EN
  , output logic     illegal
`endif
);

  always_comb begin
    e_ctl   = E_CTL_NONE;
    w_ctl   = W_ALU;
    mem_ctl = 1'b0;
    case (opcode)
      OP_ADD, OP_AND: begin
        e_ctl.alu = (opcode == OP_AND) ? ALU_AND : ALU_ADD;
        e_ctl.op2 = ~imm_bit;
      end
      OP_NOT: e_ctl.alu = ALU_NOT;
      OP_BR, OP_LD, OP_ST, OP_LDI, OP_STI, OP_LEA: begin
        e_ctl.alu    = ALU_PASS;
        e_ctl.pcsel1 = PCS1_OFF9;
        e_ctl.pcsel2 = 1'b1;
        if (opcode == OP_LD || opcode == OP_LDI) w_ctl = W_MEM;
        else if (opcode == OP_LEA)               w_ctl = W_PC;
        mem_ctl = (opcode == OP_LDI) || (opcode == OP_STI);
      end
      OP_LDR, OP_STR: begin
        e_ctl.alu    = ALU_PASS;
        e_ctl.pcsel1 = PCS1_OFF6;
        if (opcode == OP_LDR) w_ctl = W_MEM;
      end
      OP_JMP: begin
        e_ctl.alu    = ALU_PASS;
        e_ctl.pcsel1 = PCS1_ZERO;
      end
      default: ;
    endcase
  end

`ifdef LC3_DECODE_ILLEGAL_EN
  always_comb begin
    illegal = (opcode == OP_JSR) || (opcode == OP_RTI) ||
              (opcode == OP_RES) || (opcode == OP_TRAP);
  end
`endif

endmodule

// File: rtl/lc3_decode.sv
// LC3 decode stage: registers IR/NPC and decoded controls; flush loads a NOP bubble.
// Optional LC3_DECODE_ILLEGAL_EN adds illegal_op and sticky illegal_seen outputs.
module lc3_decode
  import lc3_pkg::*;
#(
  parameter logic [15:0] RESET_IR = 16'h0000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        enable_decode,
  input  logic        flush,
  input  logic [15:0] dout,
  input  logic [15:0] npc_in,
  output logic [15:0] ir,
  output logic [15:0] npc_out,
  output logic [5:0]  e_control,
  output logic [1:0]  w_control,
  output logic        mem_control,
  output logic        valid
`ifdef LC3_DECODE_ILLEGAL_EN
  , output logic      illegal_op,
  output logic        illegal_seen
`endif
);

  e_ctl_t e_nxt, e_q;
  w_ctl_e w_nxt, w_q;
  logic   mem_nxt;
`ifdef LC3_DECODE_ILLEGAL_EN
  logic   illegal_nxt;
`endif

  lc3_decode_ctl u_ctl (
    .opcode  (dout[15:12]),
    .imm_bit (dout[5]),
    .e_ctl   (e_nxt),
    .w_ctl   (w_nxt),
    .mem_ctl (mem_nxt)
`ifdef LC3_DECODE_ILLEGAL_EN
    , .illegal (illegal_nxt)
`endif
  );

  always_ff @(posedge clock) begin
    if (reset || flush) begin
      ir          <= RESET_IR;
      npc_out     <= 16'h0000;
      e_q         <= E_CTL_NONE;
      w_q         <= W_ALU;
      mem_control <= 1'b0;
      valid       <= 1'b0;
    end else if (enable_decode) begin
      ir          <= dout;
      npc_out     <= npc_in;
      e_q         <= e_nxt;
      w_q         <= w_nxt;
      mem_control <= mem_nxt;
      valid       <= 1'b1;
    end
  end

`ifdef LC3_DECODE_ILLEGAL_EN
  // illegal_seen survives flush; only reset clears it
  always_ff @(posedge clock) begin
    if (reset) begin
      illegal_op   <= 1'b0;
      illegal_seen <= 1'b0;
    end else if (flush) begin
      illegal_op   <= 1'b0;
    end else if (enable_decode) begin
      illegal_op   <= illegal_nxt;
      illegal_seen <= illegal_seen | illegal_nxt;
    end
  end
`endif

  assign e_control = e_q;
  assign w_control = w_q;

endmodule
